// File: rtl/dat_chunk_loader.sv
// rtl/dat_chunk_loader.sv - write sequencer streaming one compressed chunk into Dat_Chunk_Comb
// Optional nonzero-byte counter enabled by defining DAT_CHUNK_LOADER_NZ_COUNT_EN.
`ifndef MEM_SIZE
`define MEM_SIZE 512
`endif
`ifndef BUS_SIZE
`define BUS_SIZE 128
`endif

module dat_chunk_loader #(
  localparam int BEAT_NUM = `MEM_SIZE / `BUS_SIZE,
  localparam int CNT_W    = (BEAT_NUM > 1) ? $clog2(BEAT_NUM) : 1,
  localparam int NZ_W     = $clog2(`MEM_SIZE + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [`BUS_SIZE-1:0]    in_sparsemap_i,
  input  logic [`BUS_SIZE*8-1:0]  in_nonzero_data_i,
  output logic [`BUS_SIZE-1:0]    wr_sparsemap_o,
  output logic [`BUS_SIZE*8-1:0]  wr_nonzero_data_o,
  output logic                    wr_valid_o,
  output logic [CNT_W-1:0]        wr_count_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic [NZ_W-1:0]         nz_count_o
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [`BUS_SIZE-1:0]     wr_sparsemap_q;
  logic [`BUS_SIZE*8-1:0]   wr_nonzero_data_q;
  logic                     wr_valid_q;
  logic [CNT_W-1:0]         wr_count_q;
  logic                     accept;
  logic                     last_beat;

  // Handshake and status are pure state decodes so reset clears them immediately.
  assign in_ready_o = (state_q == LOAD);
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);
  assign accept     = in_ready_o && in_valid_i;
  assign last_beat  = (cnt_q == CNT_W'(BEAT_NUM - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (accept) begin
          cnt_d = last_beat ? '0 : cnt_q + CNT_W'(1);
          if (last_beat) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q           <= IDLE;
      cnt_q             <= '0;
      wr_sparsemap_q    <= '0;
      wr_nonzero_data_q <= '0;
      wr_valid_q        <= 1'b0;
      wr_count_q        <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_valid_q <= accept;
      if (accept) begin
        wr_sparsemap_q    <= in_sparsemap_i;
        wr_nonzero_data_q <= in_nonzero_data_i;
        wr_count_q        <= cnt_q;
      end
    end
  end

  assign wr_sparsemap_o    = wr_sparsemap_q;
  assign wr_nonzero_data_o = wr_nonzero_data_q;
  assign wr_valid_o        = wr_valid_q;
  assign wr_count_o        = wr_count_q;

`ifdef DAT_CHUNK_LOADER_NZ_COUNT_EN
  logic [NZ_W-1:0] nz_q, nz_d, beat_pop;

  always_comb begin
    beat_pop = '0;
    for (int i = 0; i < `BUS_SIZE; i++) begin
      beat_pop = beat_pop + NZ_W'(in_sparsemap_i[i]);
    end
  end

  // Total never exceeds MEM_SIZE, so NZ_W bits cannot overflow.
  always_comb begin
    nz_d = nz_q;
    if (state_q == IDLE && start_i) nz_d = '0;
    else if (accept)                nz_d = nz_q + beat_pop;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) nz_q <= '0;
    else       nz_q <= nz_d;
  end

  assign nz_count_o = nz_q;
`else
  assign nz_count_o = '0;
`endif

endmodule

// File: tb/tb_dat_chunk_loader.sv
// tb/tb_dat_chunk_loader.sv - directed table-driven bench for dat_chunk_loader (MEM_SIZE=512, BUS_SIZE=128)
`ifndef MEM_SIZE
`define MEM_SIZE 512
`endif
`ifndef BUS_SIZE
`define BUS_SIZE 128
`endif

module tb_dat_chunk_loader;

  logic                   clk_i = 1'b0;
  logic                   rst_i = 1'b0;
  logic                   start_i = 1'b0;
  logic                   in_valid_i = 1'b0;
  logic                   in_ready_o;
  logic [127:0]           in_sparsemap_i = '0;
  logic [1023:0]          in_nonzero_data_i = '0;
  logic [127:0]           wr_sparsemap_o;
  logic [1023:0]          wr_nonzero_data_o;
  logic                   wr_valid_o;
  logic [1:0]             wr_count_o;
  logic                   busy_o;
  logic                   done_o;
  logic [9:0]             nz_count_o;

  dat_chunk_loader dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .in_sparsemap_i(in_sparsemap_i), .in_nonzero_data_i(in_nonzero_data_i),
    .wr_sparsemap_o(wr_sparsemap_o), .wr_nonzero_data_o(wr_nonzero_data_o),
    .wr_valid_o(wr_valid_o), .wr_count_o(wr_count_o),
    .busy_o(busy_o), .done_o(done_o), .nz_count_o(nz_count_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [1023:0] beat_data(input logic [127:0] sm);
    beat_data = {8{~{sm[63:0], sm[127:64]}}};
  endfunction

  function automatic logic [9:0] nz(input int n);
`ifdef DAT_CHUNK_LOADER_NZ_COUNT_EN
    nz = 10'(n);
`else
    nz = 10'(0) & 10'(n);
`endif
  endfunction

  function automatic logic [15:0] e(input logic rdy, input logic val, input logic [1:0] cnt,
                                    input logic dn, input logic bsy, input logic [9:0] n);
    e = {rdy, val, cnt, dn, bsy, n};
  endfunction

  function automatic logic [15:0] outs();
    outs = {in_ready_o, wr_valid_o, wr_count_o, done_o, busy_o, nz_count_o};
  endfunction

  // Downstream chunk model: a presented beat is written at the following edge.
  logic [127:0] mem [4];
  initial for (int k = 0; k < 4; k++) mem[k] = '0;
  always @(negedge clk_i) begin
    if (wr_valid_o && !rst_i) begin
      mem[wr_count_o] = wr_sparsemap_o;
      check("wr_data_pairing", 512'(wr_nonzero_data_o), 512'(beat_data(wr_sparsemap_o)));
    end
  end

  typedef struct {
    logic         st;
    logic         v;
    logic [127:0] sm;
    logic [15:0]  exp;
    logic         mchk;
  } vec_t;

  vec_t         tbl[$];
  logic [511:0] exp_mem[3];
  localparam logic [127:0] ONES = {128{1'b1}};

  initial begin
    int mc = 0;
    exp_mem[0] = {128'hF, 128'h7, 128'h3, 128'h1};
    exp_mem[1] = {128'h0, 128'hF0, 128'h80, 128'h5};
    exp_mem[2] = {4{ONES}};

    // chunk 1: no bubbles, valid in IDLE ignored
    tbl.push_back('{1'b0, 1'b1, 128'h0, e(0,0,0,0,0,nz(0)),  1'b0});
    tbl.push_back('{1'b1, 1'b1, 128'h1, e(1,0,0,0,1,nz(0)),  1'b0});
    tbl.push_back('{1'b0, 1'b1, 128'h1, e(1,1,0,0,1,nz(1)),  1'b0});
    tbl.push_back('{1'b0, 1'b1, 128'h3, e(1,1,1,0,1,nz(3)),  1'b0});
    tbl.push_back('{1'b0, 1'b1, 128'h7, e(1,1,2,0,1,nz(6)),  1'b0});
    tbl.push_back('{1'b0, 1'b1, 128'hF, e(0,1,3,1,1,nz(10)), 1'b0});
    tbl.push_back('{1'b0, 1'b1, 128'h0, e(0,0,3,0,0,nz(10)), 1'b1});
    // chunk 2: two bubble cycles between beats 1 and 2
    tbl.push_back('{1'b1, 1'b0, 128'h0,  e(1,0,3,0,1,nz(0)), 1'b0});
    tbl.push_back('{1'b0, 1'b1, 128'h5,  e(1,1,0,0,1,nz(2)), 1'b0});
    tbl.push_back('{1'b0, 1'b1, 128'h80, e(1,1,1,0,1,nz(3)), 1'b0});
    tbl.push_back('{1'b0, 1'b0, 128'h80, e(1,0,1,0,1,nz(3)), 1'b0});
    tbl.push_back('{1'b0, 1'b0, 128'h80, e(1,0,1,0,1,nz(3)), 1'b0});
    tbl.push_back('{1'b0, 1'b1, 128'hF0, e(1,1,2,0,1,nz(7)), 1'b0});
    tbl.push_back('{1'b0, 1'b1, 128'h0,  e(0,1,3,1,1,nz(7)), 1'b0});
    // chunk 3: start held high throughout, all-ones sparsemap
    tbl.push_back('{1'b1, 1'b1, ONES, e(0,0,3,0,0,nz(7)),   1'b1});
    tbl.push_back('{1'b1, 1'b1, ONES, e(1,0,3,0,1,nz(0)),   1'b0});
    tbl.push_back('{1'b1, 1'b1, ONES, e(1,1,0,0,1,nz(128)), 1'b0});
    tbl.push_back('{1'b1, 1'b1, ONES, e(1,1,1,0,1,nz(256)), 1'b0});
    tbl.push_back('{1'b1, 1'b1, ONES, e(1,1,2,0,1,nz(384)), 1'b0});
    tbl.push_back('{1'b1, 1'b1, ONES, e(0,1,3,1,1,nz(512)), 1'b0});
    tbl.push_back('{1'b1, 1'b1, ONES, e(0,0,3,0,0,nz(512)), 1'b1});
    // chunk 4 starts in the first IDLE cycle, interrupted by reset after beat 1
    tbl.push_back('{1'b1, 1'b0, 128'h0, e(1,0,3,0,1,nz(0)), 1'b0});
    tbl.push_back('{1'b1, 1'b1, 128'h3, e(1,1,0,0,1,nz(2)), 1'b0});
    tbl.push_back('{1'b0, 1'b1, 128'h1, e(1,1,1,0,1,nz(3)), 1'b0});

    // asynchronous reset pulse mid-cycle, valid held high
    in_valid_i = 1'b1;
    #1 rst_i = 1'b1;
    #1;
    check("reset_ctl", 512'(outs()), 512'(e(0,0,0,0,0,10'd0)));
    check("reset_smap", 512'(wr_sparsemap_o), 512'(0));
    @(negedge clk_i);
    rst_i = 1'b0;

    foreach (tbl[i]) begin
      @(negedge clk_i);
      start_i           = tbl[i].st;
      in_valid_i        = tbl[i].v;
      in_sparsemap_i    = tbl[i].sm;
      in_nonzero_data_i = beat_data(tbl[i].sm);
      @(posedge clk_i);
      #1;
      check($sformatf("vec%0d", i), 512'(outs()), 512'(tbl[i].exp));
      if (tbl[i].mchk) begin
        check($sformatf("chunk_mem%0d", mc), {mem[3], mem[2], mem[1], mem[0]}, exp_mem[mc]);
        mc++;
      end
    end

    // reset during LOAD clears everything immediately
    @(negedge clk_i);
    start_i    = 1'b0;
    in_valid_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    check("midload_rst_ctl", 512'(outs()), 512'(e(0,0,0,0,0,10'd0)));
    check("midload_rst_smap", 512'(wr_sparsemap_o), 512'(0));
    check("midload_rst_data", 512'(wr_nonzero_data_o[511:0]), 512'(0));
    @(negedge clk_i);
    rst_i      = 1'b0;
    in_valid_i = 1'b1;
    in_sparsemap_i = 128'h7;
    in_nonzero_data_i = beat_data(128'h7);
    @(posedge clk_i);
    #1;
    check("post_rst_idle", 512'(outs()), 512'(e(0,0,0,0,0,10'd0)));
    @(negedge clk_i);
    start_i    = 1'b1;
    in_valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("restart_load", 512'(outs()), 512'(e(1,0,0,0,1,nz(0))));
    @(negedge clk_i);
    start_i    = 1'b0;
    in_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("restart_beat0", 512'(outs()), 512'(e(1,1,0,0,1,nz(3))));
    check("restart_smap", 512'(wr_sparsemap_o), 512'(128'h7));

    @(negedge clk_i);
    in_valid_i = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
